// File: rtl/alu_txn_sequencer.sv
// ============================================================================
// Module   : alu_txn_sequencer
// Purpose  : Assembles ALU operations from a byte stream, holds the operands
//            on registered outputs, and returns the captured result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_txn_sequencer #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic [7:0] res_data,
    output logic       res_zero,
    output logic       res_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic [7:0] txn_count
);

    localparam logic [2:0] S_GET_HDR = 3'd0;
    localparam logic [2:0] S_GET_A   = 3'd1;
    localparam logic [2:0] S_GET_B   = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_RESULT  = 3'd4;

    localparam logic [3:0] C_CNT_LAST = 4'(EXEC_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [3:0] r_cnt;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_sel;
    logic [7:0] r_res_data;
    logic       r_res_zero;
    logic       r_res_carry;
    logic       r_res_valid;
    logic [7:0] r_txn_count;

    logic       w_accept;
    logic       w_in_xfer;
    logic       w_res_xfer;
    logic       w_exec_done;
    logic       w_busy;
    logic       w_unused_hdr_bits;

    // Low header nibble carries no meaning.
    assign w_unused_hdr_bits = ^in_data[3:0];

    assign w_in_xfer  = in_valid & in_ready;
    assign w_res_xfer = r_res_valid & res_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_GET_HDR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_GET_HDR: if (w_in_xfer)   w_next_state = in_data[4] ? S_GET_B : S_GET_A;
            S_GET_A:   if (w_in_xfer)   w_next_state = S_GET_B;
            S_GET_B:   if (w_in_xfer)   w_next_state = S_EXEC;
            S_EXEC:    if (w_exec_done) w_next_state = S_RESULT;
            S_RESULT:  if (w_res_xfer)  w_next_state = S_GET_HDR;
            default:                    w_next_state = S_GET_HDR;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_accept    = 1'b0;
        w_busy      = 1'b1;
        w_exec_done = 1'b0;
        case (r_state)
            S_GET_HDR: begin
                w_accept = 1'b1;
                w_busy   = 1'b0;
            end
            S_GET_A:  w_accept = 1'b1;
            S_GET_B:  w_accept = 1'b1;
            S_EXEC:   w_exec_done = (r_cnt == C_CNT_LAST);
            default: begin
                w_accept    = 1'b0;
                w_exec_done = 1'b0;
            end
        endcase
    end

    // Held low while reset is applied so the stream never sees a ready during reset.
    assign in_ready = w_accept & ~rst;
    assign busy     = w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_alu_a     <= 8'd0;
            r_alu_b     <= 8'd0;
            r_alu_sel   <= 3'd0;
            r_res_data  <= 8'd0;
            r_res_zero  <= 1'b0;
            r_res_carry <= 1'b0;
            r_res_valid <= 1'b0;
            r_txn_count <= 8'd0;
        end else begin
            case (r_state)
                S_GET_HDR: begin
                    if (w_in_xfer) begin
                        r_alu_sel <= in_data[7:5];
                        if (in_data[4]) begin
                            r_alu_a <= r_res_data;
                        end
                    end
                end
                S_GET_A: begin
                    if (w_in_xfer) begin
                        r_alu_a <= in_data;
                    end
                end
                S_GET_B: begin
                    if (w_in_xfer) begin
                        r_alu_b <= in_data;
                        r_cnt   <= 4'd0;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_exec_done) begin
                        r_res_data  <= alu_result;
                        r_res_zero  <= alu_zero;
                        r_res_carry <= alu_carry;
                        r_res_valid <= 1'b1;
                    end
                end
                S_RESULT: begin
                    // Result registers persist past the handshake as the chain source.
                    if (w_res_xfer) begin
                        r_res_valid <= 1'b0;
                        r_txn_count <= r_txn_count + 8'd1;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_data  = r_res_data;
    assign res_zero  = r_res_zero;
    assign res_carry = r_res_carry;
    assign res_valid = r_res_valid;
    assign txn_count = r_txn_count;

endmodule

`default_nettype wire
